// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

endpackage

// File: rtl/div_restoring_seq_if.sv
// Start/result valid-ready bundle of the DIV/MOD unit.
interface div_restoring_seq_if #(
    parameter int unsigned word_width = 8
);

    logic                  START_VALID;
    logic                  START_READY;
    logic [word_width-1:0] DIVIDEND;
    logic [word_width-1:0] DIVISOR;
    logic                  RES_VALID;
    logic                  RES_READY;
    logic [word_width-1:0] QUOTIENT;
    logic [word_width-1:0] REMAINDER;
    logic                  DIV_BY_ZERO;

    modport master (
        output START_VALID, DIVIDEND, DIVISOR, RES_READY,
        input  START_READY, RES_VALID, QUOTIENT, REMAINDER, DIV_BY_ZERO
    );

    modport slave (
        input  START_VALID, DIVIDEND, DIVISOR, RES_READY,
        output START_READY, RES_VALID, QUOTIENT, REMAINDER, DIV_BY_ZERO
    );

endinterface

// File: rtl/RCA_M.sv
// Parameterised ripple-carry adder: S = A + B + C_IN.
module RCA_M #(
    parameter int unsigned word_width = 8
) (
    input  logic [word_width-1:0] A,
    input  logic [word_width-1:0] B,
    input  logic                  C_IN,
    output logic [word_width-1:0] S,
    output logic                  C_OUT
);

    logic [word_width:0] carry;

    always_comb begin
        carry    = '0;
        S        = '0;
        carry[0] = C_IN;
        for (int unsigned i = 0; i < word_width; i++) begin
            S[i]       = A[i] ^ B[i] ^ carry[i];
            carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
    end

    assign C_OUT = carry[word_width];

endmodule

// File: rtl/div_restoring_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// trial subtraction through a single RCA_M.
module div_restoring_seq
    import div_pkg::*;
#(
    parameter int unsigned word_width = 8
) (
    input logic                 CLK,
    input logic                 RESET,
    div_restoring_seq_if.slave  bus
);

    localparam int unsigned           CNT_W    = $clog2(word_width);
    localparam logic [word_width-1:0] ALL_ONES = '1;

    div_state_t            state_q, state_d;
    logic [word_width:0]   p_q, p_d;
    logic [word_width-1:0] q_q, q_d;
    logic [word_width-1:0] d_q, d_d;
    logic [word_width-1:0] quot_q, quot_d;
    logic [word_width-1:0] rem_q, rem_d;
    logic                  dbz_q, dbz_d;
    logic                  res_valid_q, res_valid_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [word_width:0]   p_shift;
    logic [word_width:0]   trial;
    logic                  no_borrow;

    assign p_shift = (p_q << 1) | {{word_width{1'b0}}, q_q[word_width-1]};

    // P' - D computed as P' + ~D + 1; carry out set means no borrow.
    RCA_M #(.word_width(word_width + 1)) u_trial_sub (
        .A     (p_shift),
        .B     (~{1'b0, d_q}),
        .C_IN  (1'b1),
        .S     (trial),
        .C_OUT (no_borrow)
    );

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        q_d         = q_q;
        d_d         = d_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        dbz_d       = dbz_q;
        res_valid_d = res_valid_q;
        cnt_d       = cnt_q;
        case (state_q)
            DIV_IDLE: begin
                if (bus.START_VALID) begin
                    if (bus.DIVISOR == '0) begin
                        state_d     = DIV_DONE;
                        quot_d      = ALL_ONES;
                        rem_d       = bus.DIVIDEND;
                        dbz_d       = 1'b1;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d = DIV_BUSY;
                        q_d     = bus.DIVIDEND;
                        d_d     = bus.DIVISOR;
                        p_d     = '0;
                        cnt_d   = CNT_W'(word_width - 1);
                    end
                end
            end
            DIV_BUSY: begin
                p_d   = no_borrow ? trial : p_shift;
                q_d   = {q_q[word_width-2:0], no_borrow};
                cnt_d = cnt_q - 1'b1;
                // Last iteration writes the result registers directly so DONE shows it at once.
                if (cnt_q == '0) begin
                    state_d     = DIV_DONE;
                    quot_d      = q_d;
                    rem_d       = p_d[word_width-1:0];
                    dbz_d       = 1'b0;
                    res_valid_d = 1'b1;
                end
            end
            DIV_DONE: begin
                if (bus.RES_READY) begin
                    state_d     = DIV_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = DIV_IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= DIV_IDLE;
            p_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            res_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            q_q         <= q_d;
            d_q         <= d_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
            res_valid_q <= res_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.START_READY = (state_q == DIV_IDLE);
    assign bus.RES_VALID   = res_valid_q;
    assign bus.QUOTIENT    = quot_q;
    assign bus.REMAINDER   = rem_q;
    assign bus.DIV_BY_ZERO = dbz_q;

endmodule
